// File: rtl/sr165_pkg.sv
// sr165_pkg: shared definitions for the 74xx165 chain scanner.
//   state_t           - scan sequencer states
//   LOAD_HALF_PERIODS - sr_clk half-periods spent with the load strobe asserted
//   cnt_width()       - counter width helper ($clog2 with a floor of 1 bit)
package sr165_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    UPDATE   = 3'd4
  } state_t;

  localparam int unsigned LOAD_HALF_PERIODS = 32'd2;

  // Width needed to count 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/sr165_debounce.sv
// sr165_debounce: per-bit debounce filter applied once per completed scan.
// Each bit keeps a candidate value and a saturating agreement counter. A raw
// bit that disagrees with its candidate replaces it and restarts the count;
// a bit of q only follows its candidate once the counter is saturated.
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   strobe     - one-cycle pulse when raw holds a complete scan
//   raw        - freshly deserialised word
//   q_cur      - currently committed word (held for unsettled bits)
//   q          - word to commit on this strobe (combinational; the scanner
//                registers it)
module sr165_debounce
  import sr165_pkg::*;
#(
  parameter int unsigned       N_BITS           = 16,
  parameter int unsigned       DEBOUNCE_SAMPLES = 4,
  parameter logic [N_BITS-1:0] RESET_VALUE      = {N_BITS{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe,
  input  logic [N_BITS-1:0] raw,
  input  logic [N_BITS-1:0] q_cur,
  output logic [N_BITS-1:0] q
);

  localparam int unsigned     CW  = cnt_width(DEBOUNCE_SAMPLES);
  localparam logic [CW-1:0]   SAT = CW'(DEBOUNCE_SAMPLES - 32'd1);

  logic [N_BITS-1:0] cand_r;
  logic [N_BITS-1:0] cand_next_s;
  logic [CW-1:0]     cnt_r      [N_BITS];
  logic [CW-1:0]     cnt_next_s [N_BITS];

  // Next candidate/counter per bit and the resulting filtered word
  always_comb begin
    cand_next_s = cand_r;
    cnt_next_s  = cnt_r;
    q           = q_cur;
    for (int i = 0; i < N_BITS; i++) begin
      if (raw[i] != cand_r[i]) begin
        cand_next_s[i] = raw[i];
        cnt_next_s[i]  = CW'(0);
      end else if (cnt_r[i] == SAT) begin
        cnt_next_s[i] = SAT;
      end else begin
        cnt_next_s[i] = cnt_r[i] + CW'(1);
      end
      if (cnt_next_s[i] == SAT) begin
        q[i] = cand_next_s[i];
      end else begin
        q[i] = q_cur[i];
      end
    end
  end

  // Filter state: starts settled on the reset word, advances once per scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_r <= RESET_VALUE;
      for (int i = 0; i < N_BITS; i++) begin
        cnt_r[i] <= SAT;
      end
    end else if (strobe) begin
      cand_r <= cand_next_s;
      cnt_r  <= cnt_next_s;
    end else begin
      cand_r <= cand_r;
      cnt_r  <= cnt_r;
    end
  end

endmodule

// File: rtl/sr165_scanner.sv
// sr165_scanner: periodic scanner for a chain of 74xx165 PISO registers.
// Each scan pulses the parallel load (sr_load_n) for 2*CLK_DIV cycles, then
// issues N_BITS sr_clk periods, sampling sr_data just before each rising
// edge, and commits the word to q in a one-cycle UPDATE state.
// Scan period: 2*CLK_DIV + 2*N_BITS*CLK_DIV + 1 cycles.
// Build option: define SR165_SCANNER_DEBOUNCE_EN to route each scan through
// the per-bit debounce filter (sr165_debounce) before committing.
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset (aborts a scan, no commit)
//   enable    - run continuous scans; sampled only in IDLE and UPDATE
//   sr_data   - QH of the last 165 in the chain
//   sr_clk    - chain shift clock (chain shifts on its rising edge)
//   sr_load_n - chain parallel load, active low
//   q         - committed word; first bit shifted in lands in q[N_BITS-1]
//   scan_done - one-cycle pulse when q is committed
//   changed   - pulse with scan_done when the committed word differs
module sr165_scanner
  import sr165_pkg::*;
#(
  parameter int unsigned       N_BITS           = 16,
  parameter int unsigned       CLK_DIV          = 1,
  parameter logic [N_BITS-1:0] RESET_VALUE      = {N_BITS{1'b1}},
  parameter int unsigned       DEBOUNCE_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sr_data,
  output logic              sr_clk,
  output logic              sr_load_n,
  output logic [N_BITS-1:0] q,
  output logic              scan_done,
  output logic              changed
);

  localparam int unsigned CNT_W  = cnt_width(N_BITS + 32'd1);
  localparam int unsigned DIV_W  = cnt_width(CLK_DIV);
  localparam int unsigned HALF_W = cnt_width(LOAD_HALF_PERIODS);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_BITS - 32'd1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 32'd1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(LOAD_HALF_PERIODS - 32'd1);

  state_t             state_r;
  logic [DIV_W-1:0]   div_r;
  logic [HALF_W-1:0]  half_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [N_BITS-1:0]  shift_r;
  logic               sr_clk_r;
  logic               sr_load_n_r;
  logic [N_BITS-1:0]  q_r;
  logic               scan_done_r;
  logic               changed_r;

  logic               div_last_s;
  logic               commit_s;
  logic [N_BITS-1:0]  word_s;

  assign div_last_s = (div_r == DIV_LAST);

  // Last sr_clk high phase of the last bit: the word is complete this cycle
  always_comb begin
    if ((state_r == SHIFT_HI) && div_last_s && (cnt_r == CNT_LAST)) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

`ifdef SR165_SCANNER_DEBOUNCE_EN
  sr165_debounce #(
    .N_BITS           (N_BITS),
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
    .RESET_VALUE      (RESET_VALUE)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (commit_s),
    .raw    (shift_r),
    .q_cur  (q_r),
    .q      (word_s)
  );
`else
  assign word_s = shift_r;
`endif

  // Scan sequencer: chain strobes, bit capture and word commit. Strobe
  // outputs are written with the value of the state being entered, so the
  // load and shift clock never toggle on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      div_r       <= DIV_W'(0);
      half_r      <= HALF_W'(0);
      cnt_r       <= CNT_W'(0);
      shift_r     <= {N_BITS{1'b0}};
      sr_clk_r    <= 1'b0;
      sr_load_n_r <= 1'b1;
      q_r         <= RESET_VALUE;
      scan_done_r <= 1'b0;
      changed_r   <= 1'b0;
    end else begin
      scan_done_r <= 1'b0;
      changed_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          sr_clk_r <= 1'b0;
          if (enable) begin
            state_r     <= LOAD;
            sr_load_n_r <= 1'b0;
            div_r       <= DIV_W'(0);
            half_r      <= HALF_W'(0);
          end else begin
            sr_load_n_r <= 1'b1;
          end
        end
        LOAD: begin
          if (div_last_s) begin
            div_r <= DIV_W'(0);
            if (half_r == HALF_LAST) begin
              state_r     <= SHIFT_LO;
              half_r      <= HALF_W'(0);
              cnt_r       <= CNT_W'(0);
              sr_load_n_r <= 1'b1;
            end else begin
              half_r <= half_r + HALF_W'(1);
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        SHIFT_LO: begin
          if (div_last_s) begin
            // QH still shows the current bit; the rising edge follows
            for (int i = 0; i < N_BITS; i++) begin
              if (cnt_r == CNT_W'(N_BITS - 32'd1 - 32'(i))) begin
                shift_r[i] <= sr_data;
              end
            end
            div_r    <= DIV_W'(0);
            sr_clk_r <= 1'b1;
            state_r  <= SHIFT_HI;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (div_last_s) begin
            div_r    <= DIV_W'(0);
            sr_clk_r <= 1'b0;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (commit_s) begin
              state_r     <= UPDATE;
              q_r         <= word_s;
              scan_done_r <= 1'b1;
              changed_r   <= (word_s != q_r);
            end else begin
              state_r <= SHIFT_LO;
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        UPDATE: begin
          div_r  <= DIV_W'(0);
          half_r <= HALF_W'(0);
          if (enable) begin
            state_r     <= LOAD;
            sr_load_n_r <= 1'b0;
          end else begin
            state_r     <= IDLE;
            sr_load_n_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          sr_clk_r    <= 1'b0;
          sr_load_n_r <= 1'b1;
        end
      endcase
    end
  end

  assign sr_clk    = sr_clk_r;
  assign sr_load_n = sr_load_n_r;
  assign q         = q_r;
  assign scan_done = scan_done_r;
  assign changed   = changed_r;

endmodule
